// File: rtl/dsram_arbiter.sv
// Data SRAM arbiter: core memory stage vs. external bus master (debug/DMA).
// Latency: grant and SRAM select are combinational; read data returns one cycle after a granted read.
// Backpressure: core stalls when it loses; ext holds req until ext_gnt; a starvation counter forces ext progress.
// Optional: define DSRAM_ARB_PERF_EN to add the stall/grant performance counters.
module dsram_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 4
) (
   input  logic        clk,
   input  logic        cpurst,
   input  logic        core_cs,
   input  logic        core_we,
   input  logic [31:0] core_addr,
   input  logic [3:0]  core_ben,
   input  logic [31:0] core_wdata,
   input  logic        core_split,
   output logic        core_stall,
   output logic [31:0] core_rdata,
   input  logic        ext_req,
   input  logic        ext_we,
   input  logic [31:0] ext_addr,
   input  logic [3:0]  ext_ben,
   input  logic [31:0] ext_wdata,
   output logic        ext_gnt,
   output logic        ext_rvalid,
   output logic [31:0] ext_rdata,
   output logic        sram_cs,
   output logic        sram_we,
   output logic [31:0] sram_addr,
   output logic [3:0]  sram_ben,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
`ifdef DSRAM_ARB_PERF_EN
   ,
   output logic [31:0] perf_core_stall_cnt,
   output logic [31:0] perf_ext_grant_cnt
`endif
);

   typedef enum logic [1:0] {ARB_IDLE, ARB_CORE, ARB_EXT, ARB_LOCK} arb_state_t;
   typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_EXT} rd_owner_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_t       state, state_nxt;
   rd_owner_t        rd_owner;
   logic [CNT_W-1:0] wait_cnt;
   logic             core_gnt;
   logic             ext_gnt_w;

   // State register: owner of the previous cycle
   always_ff @(posedge clk or posedge cpurst) begin
      if (cpurst) state <= ARB_IDLE;
      else        state <= state_nxt;
   end

   // Grant decision in priority order; nothing is granted while in reset.
   // A split store's second half beats even a starved ext; a flushed split
   // (LOCK with no core request) simply falls through to the normal rules.
   always_comb begin
      core_gnt  = 1'b0;
      ext_gnt_w = 1'b0;
      if (!cpurst) begin
         if (state == ARB_LOCK && core_cs)        core_gnt  = 1'b1;
         else if (ext_req && wait_cnt == LIMIT)   ext_gnt_w = 1'b1;
         else if (core_cs)                        core_gnt  = 1'b1;
         else if (ext_req)                        ext_gnt_w = 1'b1;
      end
   end

   // Next state follows whoever was granted this cycle
   always_comb begin
      state_nxt = ARB_IDLE;
      if (core_gnt)       state_nxt = core_split ? ARB_LOCK : ARB_CORE;
      else if (ext_gnt_w) state_nxt = ARB_EXT;
   end

   // SRAM mux and handshake outputs; payload defaults to core when idle
   always_comb begin
      sram_cs    = core_gnt | ext_gnt_w;
      sram_we    = ext_gnt_w ? ext_we    : (core_gnt & core_we);
      sram_addr  = ext_gnt_w ? ext_addr  : core_addr;
      sram_ben   = ext_gnt_w ? ext_ben   : core_ben;
      sram_wdata = ext_gnt_w ? ext_wdata : core_wdata;
      ext_gnt    = ext_gnt_w;
      core_stall = core_cs & ~core_gnt & ~cpurst;
   end

   // Starvation counter: counts denied ext cycles, saturating at the limit
   always_ff @(posedge clk or posedge cpurst) begin
      if (cpurst)                     wait_cnt <= '0;
      else if (!ext_req || ext_gnt_w) wait_cnt <= '0;
      else if (wait_cnt != LIMIT)     wait_cnt <= wait_cnt + CNT_W'(1);
   end

   // Remember who issued a read so the return data can be flagged next cycle
   always_ff @(posedge clk or posedge cpurst) begin
      if (cpurst)                      rd_owner <= RD_NONE;
      else if (core_gnt && !core_we)   rd_owner <= RD_CORE;
      else if (ext_gnt_w && !ext_we)   rd_owner <= RD_EXT;
      else                             rd_owner <= RD_NONE;
   end

   // Read return: data shared, ext steered by rvalid, core by pipeline timing
   always_comb begin
      ext_rvalid = (rd_owner == RD_EXT);
      ext_rdata  = sram_rdata;
      core_rdata = sram_rdata;
   end

`ifdef DSRAM_ARB_PERF_EN
   // Free-running performance counters, wrapping at 2^32
   always_ff @(posedge clk or posedge cpurst) begin
      if (cpurst) begin
         perf_core_stall_cnt <= '0;
         perf_ext_grant_cnt  <= '0;
      end else begin
         if (core_stall) perf_core_stall_cnt <= perf_core_stall_cnt + 32'd1;
         if (ext_gnt_w)  perf_ext_grant_cnt  <= perf_ext_grant_cnt + 32'd1;
      end
   end
`endif

endmodule
